// File: rtl/jpeg_bitstream_feeder.sv
// JPEG entropy-segment byte stream to decoder word feeder: unstuffs FF00, drops fill/RSTn,
// packs bytes MSB-first into OUT_W words, pads with 1s on EOI. Ports: byte in, word out.
module jpeg_bitstream_feeder #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             request,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic             rst_marker,
  output logic             marker_err,
  output logic             eoi_done
);

  localparam int NB = OUT_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] FULL = CW'(NB);
  localparam logic [OUT_W-1:0] ONES = '1;

  typedef enum logic [2:0] {
    IDLE, DATA, FF_SEEN, FLUSH, DONE
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] pack;
  logic [CW-1:0]    count;

  logic             pack_full;
  logic             out_free;
  logic             move;
  logic             accept;
  logic             ins;
  logic [7:0]       ins_val;
  logic             pad;
  logic [OUT_W-1:0] base_pack;
  logic [CW-1:0]    base_cnt;
  logic [CW+2:0]    sh;
  logic [OUT_W-1:0] pack_nx;
  logic [CW-1:0]    cnt_nx;
  logic             bypass;

  assign pack_full  = (count == FULL);
  assign out_free   = !valid_out || request;
  assign move       = pack_full && out_free;
  assign byte_ready = ((state == DATA) || (state == FF_SEEN))
                      && (!pack_full || move);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    base_pack = move ? '0 : pack;
    base_cnt  = move ? '0 : count;
    ins       = 1'b0;
    ins_val   = byte_in;
    if (accept && (state == DATA) && (byte_in != 8'hFF))
      ins = 1'b1;
    if (accept && (state == FF_SEEN) && (byte_in == 8'h00)) begin
      ins     = 1'b1;
      ins_val = 8'hFF;
    end
    pad     = (state == FLUSH) && (base_cnt != '0) && (base_cnt != FULL);
    sh      = {base_cnt, 3'b000};
    pack_nx = base_pack;
    cnt_nx  = base_cnt;
    if (ins) begin
      pack_nx = base_pack | ({ins_val, {(OUT_W-8){1'b0}}} >> sh);
      cnt_nx  = base_cnt + 1'b1;
    end else if (pad) begin
      pack_nx = base_pack | (ONES >> sh);
      cnt_nx  = FULL;
    end
    // A word completed this cycle goes straight to the free output register
    bypass = !move && (cnt_nx == FULL) && out_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pack       <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      rst_marker <= 1'b0;
      marker_err <= 1'b0;
      eoi_done   <= 1'b0;
    end else begin
      rst_marker <= 1'b0;
      marker_err <= 1'b0;
      if (move) begin
        data_out  <= pack;
        valid_out <= 1'b1;
      end else if (bypass) begin
        data_out  <= pack_nx;
        valid_out <= 1'b1;
      end else if (request) begin
        valid_out <= 1'b0;
      end
      pack  <= bypass ? '0 : pack_nx;
      count <= bypass ? '0 : cnt_nx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DATA;
            pack     <= '0;
            count    <= '0;
            eoi_done <= 1'b0;
          end
        end
        DATA: begin
          if (accept && (byte_in == 8'hFF))
            state <= FF_SEEN;
        end
        FF_SEEN: begin
          if (accept) begin
            unique case (1'b1)
              (byte_in == 8'h00): state <= DATA;
              (byte_in == 8'hFF): state <= FF_SEEN;
              (byte_in[7:3] == 5'b11010): begin
                rst_marker <= 1'b1;
                state      <= DATA;
              end
              (byte_in == 8'hD9): state <= FLUSH;
              default: begin
                marker_err <= 1'b1;
                state      <= DATA;
              end
            endcase
          end
        end
        FLUSH: begin
          if ((count == '0) && !valid_out) begin
            state    <= DONE;
            eoi_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jpeg_bitstream_feeder.md
Name: jpeg_bitstream_feeder

Overview:
- Responder side of the entropy decoder's `request` / `data_in` / `valid_in` word interface.
- Accepts the JPEG entropy-coded segment as a byte stream, removes 0xFF00 byte stuffing, and drops fill bytes and RSTn markers.
- Packs bytes MSB-first into OUT_W-bit words and presents them to the decoder under its request handshake.
- On the EOI marker, pads the final partial word with 1s, drains it, then stops.

Parameters:
- OUT_W, 32: output word width; must equal `IN_BUS_WIDTH`; multiple of 8, at least 16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin a new scan (accepted in IDLE or DONE only)
- byte_in  in  8  entropy-segment byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  byte accepted when byte_valid && byte_ready
- request  in  1  decoder ready; word transfers when valid_out && request
- data_out  out  OUT_W  packed word to decoder data_in
- valid_out  out  1  data_out valid (to decoder valid_in)
- rst_marker  out  1  one-cycle pulse: RSTn marker (FF D0..D7) consumed
- marker_err  out  1  one-cycle pulse: unexpected marker (FF xx, xx not in {00, FF, D0..D7, D9})
- eoi_done  out  1  level: EOI seen and final word transferred

Behaviour:
- Reset: all outputs 0, byte_ready 0, state IDLE, pack register and byte count cleared. Reset mid-word discards partial data.
- Storage: pack register (OUT_W bits, count 0..OUT_W/8) plus one output register (data_out/valid_out).
- Packing: the first byte of a word lands in [OUT_W-1:OUT_W-8]; later bytes fill downward.
- move = pack_full && (!valid_out || request).
  - On move, the pack contents load into data_out and valid_out=1 on the next cycle.
  - The pack clears; a byte accepted in the same cycle lands in slot 0.
- Latency: the byte completing a word is accepted at cycle N; the word is on data_out at N+1 if the output register is free or transferring.
- Output hold: while valid_out && !request, data_out is held stable.
- Output clear: a transfer with no concurrent move clears valid_out next cycle.
- byte_ready = (state==DATA || state==FF_SEEN) && (!pack_full || move). This is a combinational path from request.
- States:
  - IDLE: byte_ready=0. start → DATA, with count cleared and eoi_done cleared.
  - DATA:
    - accepted 0xFF → FF_SEEN, nothing packed;
    - other byte → pack it, stay.
  - FF_SEEN, next accepted byte:
    - 0x00 → pack 0xFF, → DATA;
    - 0xFF → drop (fill), stay FF_SEEN;
    - D0..D7 → drop, pulse rst_marker, → DATA;
    - D9 → FLUSH;
    - else → drop, pulse marker_err, → DATA.
  - FLUSH: byte_ready=0.
    - If count>0, fill the remaining slots with 0xFF so the pack is full, then move normally.
    - When the pack is empty and valid_out==0 → DONE.
  - DONE: eoi_done=1, byte_ready=0. start → DATA; the eoi_done clear is seen next cycle.
- start while in DATA, FF_SEEN or FLUSH is ignored.
- Pulses (rst_marker, marker_err) are registered and asserted the cycle after the marker byte is accepted.
- EOI as the first word byte (count 0): no padding word is emitted.

Test Plan:
- OUT_W=32, start, bytes 12 34 56 78 9A, request=1 → data_out 0x12345678, valid_out one cycle after 0x78 is accepted; 0x9A held in slot 0.
- Bytes 12 FF 00 34 56 → single word 0x12FF3456; no marker pulses.
- Bytes AB FF D9 → word 0xABFFFFFF transferred; then eoi_done=1, byte_ready=0; further byte_valid ignored. Next start → eoi_done=0, byte_ready=1.
- request=0, bytes 01..08 → valid_out=1, data_out 0x01020304 stable; byte_ready=0 with 05060708 in the pack. Raise request → 0x01020304 then 0x05060708 on consecutive request cycles.
- Bytes FF D3, then FF 5A, then FF FF 00 11 22 33 → rst_marker pulse, then marker_err pulse, then word 0xFF112233 (markers and fill byte dropped).
- rst asserted after 2 bytes of a word → next cycle valid_out=0, byte_ready=0, state IDLE; bytes ignored until start. The first word after restart contains only new bytes.
